// File: rtl/noc_resp_route_pkg.sv
// rtl/noc_resp_route_pkg.sv - shared widths and per-topology return-route table constants
package noc_resp_route_pkg;

    localparam int PATH_W  = 7;
    localparam int ID_W    = 4;

    // Return-route table for this topology; entry i maps ROUTE_IDS[i] to ROUTE_PATHS[i]
    localparam int ROUTE_N = 3;

    localparam logic [ROUTE_N-1:0][ID_W-1:0] ROUTE_IDS = {
        4'hA,
        4'h6,
        4'h2
    };

    localparam logic [ROUTE_N-1:0][PATH_W-1:0] ROUTE_PATHS = {
        7'b0000000,
        7'b0000110,
        7'b0000001
    };

endpackage

// File: rtl/resp_route_table.sv
// rtl/resp_route_table.sv - combinational source ID to return-route lookup
module resp_route_table
    import noc_resp_route_pkg::*;
(
    input  logic [ID_W-1:0]   source_id,
    output logic [PATH_W-1:0] path,
    output logic              hit
);

    // First matching table entry wins; unknown IDs report a miss with a zero path
    always_comb begin
        path = '0;
        hit  = 1'b0;
        for (int i = 0; i < ROUTE_N; i++) begin
            if (!hit && (source_id == ROUTE_IDS[i])) begin
                path = ROUTE_PATHS[i];
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ni_target_resp_router.sv
// rtl/ni_target_resp_router.sv - target-side response return-route router (optional RESP_ROUTE_STATS_EN)
module ni_target_resp_router
    import noc_resp_route_pkg::*;
#(
    parameter int PATH_W = noc_resp_route_pkg::PATH_W,
    parameter int ID_W   = noc_resp_route_pkg::ID_W,
    parameter int DEPTH  = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ID_W-1:0]         req_source_id,
    input  logic                    req_expects_resp,
    input  logic                    resp_valid,
    input  logic                    resp_last,
    output logic                    resp_ready,
    output logic                    hdr_valid,
    input  logic                    hdr_ready,
    output logic [PATH_W-1:0]       hdr_path,
    output logic [ID_W-1:0]         hdr_target,
    output logic                    hdr_last,
    output logic                    hdr_decode_err,
    output logic                    err_orphan,
    output logic                    err_decode
`ifdef RESP_ROUTE_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]  outstanding_cnt,
    output logic [$clog2(DEPTH):0]  outstanding_max
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ID_W-1:0]   q_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              beat_fire;
    logic              load;
    logic              orphan;

    logic [ID_W-1:0]   head_id;
    logic [PATH_W-1:0] lk_path;
    logic              lk_hit;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head_id = q_mem[rd_ptr];

    // Ready is held low while reset is asserted so every output reads 0 during reset
    assign req_ready  = !reset && !full;
    assign resp_ready = !reset && (empty || !hdr_valid || hdr_ready);

    assign push      = req_valid && req_ready && req_expects_resp;
    assign beat_fire = resp_valid && resp_ready;
    assign load      = beat_fire && !empty;
    assign pop       = load && resp_last;
    assign orphan    = beat_fire && empty;

    resp_route_table u_table (
        .source_id (head_id),
        .path      (lk_path),
        .hit       (lk_hit)
    );

    // Next occupancy: a simultaneous push and pop cancel out
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers and count
    always_ff @(posedge clock) begin
        if (push) begin
            q_mem[wr_ptr] <= req_source_id;
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    // Output register: load on an accepted beat, hold while stalled, drop valid once taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hdr_valid      <= 1'b0;
            hdr_path       <= '0;
            hdr_target     <= '0;
            hdr_last       <= 1'b0;
            hdr_decode_err <= 1'b0;
        end else if (load) begin
            hdr_valid      <= 1'b1;
            hdr_path       <= lk_hit ? lk_path : '0;
            hdr_target     <= head_id;
            hdr_last       <= resp_last;
            hdr_decode_err <= !lk_hit;
        end else if (hdr_ready) begin
            hdr_valid      <= 1'b0;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_orphan <= 1'b0;
            err_decode <= 1'b0;
        end else begin
            if (orphan) begin
                err_orphan <= 1'b1;
            end
            if (load && !lk_hit) begin
                err_decode <= 1'b1;
            end
        end
    end

`ifdef RESP_ROUTE_STATS_EN
    assign outstanding_cnt = count;

    // High-water mark of queue occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            outstanding_max <= '0;
        end else if (count_next > outstanding_max) begin
            outstanding_max <= count_next;
        end
    end
`endif

endmodule

// File: tb/tb_ni_target_resp_router.sv
// tb/tb_ni_target_resp_router.sv - directed self-checking bench for ni_target_resp_router
module tb_ni_target_resp_router;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_source_id;
    logic       req_expects_resp;
    logic       resp_valid;
    logic       resp_last;
    logic       resp_ready;
    logic       hdr_valid;
    logic       hdr_ready;
    logic [6:0] hdr_path;
    logic [3:0] hdr_target;
    logic       hdr_last;
    logic       hdr_decode_err;
    logic       err_orphan;
    logic       err_decode;
`ifdef RESP_ROUTE_STATS_EN
    logic [2:0] outstanding_cnt;
    logic [2:0] outstanding_max;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ni_target_resp_router dut (
        .clock            (clock),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_source_id    (req_source_id),
        .req_expects_resp (req_expects_resp),
        .resp_valid       (resp_valid),
        .resp_last        (resp_last),
        .resp_ready       (resp_ready),
        .hdr_valid        (hdr_valid),
        .hdr_ready        (hdr_ready),
        .hdr_path         (hdr_path),
        .hdr_target       (hdr_target),
        .hdr_last         (hdr_last),
        .hdr_decode_err   (hdr_decode_err),
        .err_orphan       (err_orphan),
        .err_decode       (err_decode)
`ifdef RESP_ROUTE_STATS_EN
        ,
        .outstanding_cnt  (outstanding_cnt),
        .outstanding_max  (outstanding_max)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [3:0] id, input logic er);
        req_valid        = 1'b1;
        req_source_id    = id;
        req_expects_resp = er;
        tick();
        req_valid        = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick(); tick();
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
        checks++; if (resp_ready !== 1'b0) begin failures++; $display("FAIL rst_resp_ready got=%b exp=0", resp_ready); end
        checks++; if ({hdr_valid, hdr_path, hdr_target, hdr_last, hdr_decode_err} !== 14'd0) begin
            failures++; $display("FAIL rst_hdr got=%b/%b/%h/%b/%b exp=all 0", hdr_valid, hdr_path, hdr_target, hdr_last, hdr_decode_err); end
        checks++; if ({err_orphan, err_decode} !== 2'b00) begin failures++; $display("FAIL rst_errs got=%b%b exp=00", err_orphan, err_decode); end
`ifdef RESP_ROUTE_STATS_EN
        checks++; if ({outstanding_cnt, outstanding_max} !== 6'd0) begin failures++; $display("FAIL rst_stats got=%0d/%0d exp=0/0", outstanding_cnt, outstanding_max); end
`endif
        reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rel_req_ready got=%b exp=1", req_ready); end
        checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL rel_resp_ready got=%b exp=1", resp_ready); end
    endtask

    task automatic test_in_order();
        logic [3:0] exp_id   [3] = '{4'h2, 4'h6, 4'hA};
        logic [6:0] exp_path [3] = '{7'b0000001, 7'b0000110, 7'b0000000};
        push(4'h2, 1'b1);
        push(4'h9, 1'b0);
        push(4'h6, 1'b1);
        push(4'hA, 1'b1);
        for (int k = 0; k < 3; k++) begin
            resp_valid = 1'b1;
            resp_last  = 1'b1;
            #1;
            checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL order_resp_ready%0d got=%b exp=1", k, resp_ready); end
            tick();
            checks++; if (hdr_valid !== 1'b1 || hdr_path !== exp_path[k] || hdr_target !== exp_id[k] || hdr_last !== 1'b1 || hdr_decode_err !== 1'b0) begin
                failures++; $display("FAIL order_hdr%0d got=v%b p%b t%h l%b e%b exp=v1 p%b t%h l1 e0", k, hdr_valid, hdr_path, hdr_target, hdr_last, hdr_decode_err, exp_path[k], exp_id[k]); end
        end
        resp_valid = 1'b0;
        tick();
        checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL order_drain got=%b exp=0", hdr_valid); end
        checks++; if ({err_orphan, err_decode} !== 2'b00) begin failures++; $display("FAIL order_errs got=%b%b exp=00", err_orphan, err_decode); end
    endtask

    task automatic test_multibeat();
        push(4'h6, 1'b1);
        for (int k = 0; k < 4; k++) begin
            resp_valid = 1'b1;
            resp_last  = (k == 3);
            tick();
            checks++; if (hdr_valid !== 1'b1 || hdr_path !== 7'b0000110 || hdr_target !== 4'h6 || hdr_last !== (k == 3)) begin
                failures++; $display("FAIL multi_beat%0d got=v%b p%b t%h l%b exp=v1 p0000110 t6 l%0d", k, hdr_valid, hdr_path, hdr_target, hdr_last, (k == 3)); end
        end
        resp_valid = 1'b0;
        tick();
        checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL multi_drain got=%b exp=0", hdr_valid); end
`ifdef RESP_ROUTE_STATS_EN
        checks++; if (outstanding_cnt !== 3'd0) begin failures++; $display("FAIL multi_cnt got=%0d exp=0", outstanding_cnt); end
`endif
    endtask

    task automatic test_full();
        logic [3:0] exp_id [4] = '{4'h6, 4'hA, 4'h2, 4'h6};
        push(4'h2, 1'b1);
        push(4'h6, 1'b1);
        push(4'hA, 1'b1);
        push(4'h2, 1'b1);
        req_valid        = 1'b1;
        req_source_id    = 4'h6;
        req_expects_resp = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready got=%b exp=0", req_ready); end
        tick();
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_ready_pop got=%b exp=0", req_ready); end
        tick();
        resp_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL full_ready_rise got=%b exp=1", req_ready); end
        checks++; if (hdr_target !== 4'h2 || hdr_valid !== 1'b1) begin failures++; $display("FAIL full_pop_hdr got=v%b t%h exp=v1 t2", hdr_valid, hdr_target); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL full_again got=%b exp=0", req_ready); end
        for (int k = 0; k < 4; k++) begin
            resp_valid = 1'b1;
            resp_last  = 1'b1;
            tick();
            checks++; if (hdr_valid !== 1'b1 || hdr_target !== exp_id[k]) begin
                failures++; $display("FAIL full_drain%0d got=v%b t%h exp=v1 t%h", k, hdr_valid, hdr_target, exp_id[k]); end
        end
        resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_decode_err();
        push(4'h5, 1'b1);
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        tick();
        resp_valid = 1'b0;
        checks++; if (hdr_valid !== 1'b1 || hdr_decode_err !== 1'b1 || hdr_path !== 7'd0 || hdr_target !== 4'h5) begin
            failures++; $display("FAIL dec_hdr got=v%b e%b p%b t%h exp=v1 e1 p0000000 t5", hdr_valid, hdr_decode_err, hdr_path, hdr_target); end
        checks++; if (err_decode !== 1'b1) begin failures++; $display("FAIL dec_sticky got=%b exp=1", err_decode); end
        tick();
        tick();
        checks++; if (err_decode !== 1'b1 || hdr_valid !== 1'b0 || err_orphan !== 1'b0) begin
            failures++; $display("FAIL dec_hold got=d%b v%b o%b exp=d1 v0 o0", err_decode, hdr_valid, err_orphan); end
    endtask

    task automatic test_orphan();
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        #1;
        checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL orph_ready got=%b exp=1", resp_ready); end
        tick();
        resp_valid = 1'b0;
        checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL orph_hdr_valid got=%b exp=0", hdr_valid); end
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orph_flag got=%b exp=1", err_orphan); end
        tick();
        checks++; if (err_orphan !== 1'b1) begin failures++; $display("FAIL orph_sticky got=%b exp=1", err_orphan); end
    endtask

    task automatic test_stall();
        push(4'h2, 1'b1);
        push(4'h6, 1'b1);
        hdr_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_last  = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (resp_ready !== 1'b0 || hdr_valid !== 1'b1 || hdr_target !== 4'h2 || hdr_path !== 7'b0000001 || hdr_last !== 1'b1) begin
                failures++; $display("FAIL stall_hold%0d got=r%b v%b t%h p%b l%b exp=r0 v1 t2 p0000001 l1", k, resp_ready, hdr_valid, hdr_target, hdr_path, hdr_last); end
            tick();
        end
        hdr_ready = 1'b1;
        #1;
        checks++; if (resp_ready !== 1'b1) begin failures++; $display("FAIL stall_release got=%b exp=1", resp_ready); end
        tick();
        resp_valid = 1'b0;
        checks++; if (hdr_valid !== 1'b1 || hdr_target !== 4'h6 || hdr_path !== 7'b0000110) begin
            failures++; $display("FAIL stall_next got=v%b t%h p%b exp=v1 t6 p0000110", hdr_valid, hdr_target, hdr_path); end
        tick();
        checks++; if (hdr_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", hdr_valid); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        push(4'h2, 1'b1);
        push(4'h6, 1'b1);
        hdr_ready  = 1'b0;
        resp_valid = 1'b1;
        resp_last  = 1'b0;
        tick();
        resp_valid = 1'b0;
        checks++; if (hdr_valid !== 1'b1 || hdr_target !== 4'h2) begin failures++; $display("FAIL mid_pre got=v%b t%h exp=v1 t2", hdr_valid, hdr_target); end
`ifdef RESP_ROUTE_STATS_EN
        checks++; if (outstanding_cnt !== 3'd2 || outstanding_max !== 3'd2) begin
            failures++; $display("FAIL mid_stats_pre got=%0d/%0d exp=2/2", outstanding_cnt, outstanding_max); end
`endif
        #2;
        reset = 1'b1;
        #1;
        checks++; if ({req_ready, resp_ready, hdr_valid, hdr_path, hdr_target, hdr_last, hdr_decode_err, err_orphan, err_decode} !== 18'd0) begin
            failures++; $display("FAIL mid_async got=%b%b%b/%b/%h/%b%b%b%b exp=all 0", req_ready, resp_ready, hdr_valid, hdr_path, hdr_target, hdr_last, hdr_decode_err, err_orphan, err_decode); end
`ifdef RESP_ROUTE_STATS_EN
        checks++; if (outstanding_cnt !== 3'd0 || outstanding_max !== 3'd0) begin
            failures++; $display("FAIL mid_stats_post got=%0d/%0d exp=0/0", outstanding_cnt, outstanding_max); end
`endif
        tick();
        reset     = 1'b0;
        hdr_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1 || hdr_valid !== 1'b0) begin failures++; $display("FAIL mid_release got=r%b v%b exp=r1 v0", req_ready, hdr_valid); end
    endtask

    initial begin
        reset            = 1'b1;
        req_valid        = 1'b0;
        req_source_id    = 4'h0;
        req_expects_resp = 1'b0;
        resp_valid       = 1'b0;
        resp_last        = 1'b0;
        hdr_ready        = 1'b1;
        test_reset();
        test_in_order();
        test_multibeat();
        test_full();
        test_decode_err();
        test_orphan();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
